// File: rtl/access_ctrl_pkg.sv
// Shared op codes, status codes, widths and FSM states for the access request sequencer.
package access_ctrl_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned STAT_W = 3;
    localparam int unsigned OP_W   = 2;

    localparam logic [OP_W-1:0] OP_ILLEGAL = 2'b00;
    localparam logic [OP_W-1:0] OP_VERIFY  = 2'b01;
    localparam logic [OP_W-1:0] OP_CHANGE  = 2'b10;
    localparam logic [OP_W-1:0] OP_LOGOUT  = 2'b11;

    localparam logic [STAT_W-1:0] ST_NONE    = 3'b000;
    localparam logic [STAT_W-1:0] ST_GRANTED = 3'b001;
    localparam logic [STAT_W-1:0] ST_DENIED  = 3'b010;
    localparam logic [STAT_W-1:0] ST_CHANGED = 3'b011;
    localparam logic [STAT_W-1:0] ST_ENG_ERR = 3'b100;
    localparam logic [STAT_W-1:0] ST_LOCKED  = 3'b110;
    localparam logic [STAT_W-1:0] ST_TIMEOUT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_LOCKOUT
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins; one-hot grant plus its index.
module rr_arbiter #(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt_c,
    output logic [IDX_W-1:0] idx_c,
    output logic             vld_c
);

    int unsigned slot;

    always_comb begin
        gnt_c = '0;
        idx_c = '0;
        vld_c = 1'b0;
        slot  = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            slot = (32'(ptr) + k) % NREQ;
            if (!vld_c && req[IDX_W'(slot)]) begin
                vld_c       = 1'b1;
                gnt_c[slot] = 1'b1;
                idx_c       = IDX_W'(slot);
            end
        end
    end

endmodule

// File: rtl/access_request_sequencer.sv
// Shares one AccessControl password engine between NREQ requesters, granted round-robin.
// Build option ACCESS_LOCKOUT_EN adds a brute-force lockout after MAX_FAILS denied verifies.
module access_request_sequencer
    import access_ctrl_pkg::*;
#(
    parameter int unsigned NREQ           = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 50000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [OP_W*NREQ-1:0]   req_op,
    input  logic [DATA_W*NREQ-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [STAT_W-1:0]      rsp_status,
    output logic [OP_W-1:0]        ac_request,
    output logic [DATA_W-1:0]      ac_data,
    output logic                   ac_data_load,
    input  logic [STAT_W-1:0]      ac_status,
    output logic                   busy,
    output logic                   locked
);

    localparam int unsigned IDX_W = $clog2(NREQ);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d, idx_q, idx_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [STAT_W-1:0]   rsp_status_q, rsp_status_d;
    logic [OP_W-1:0]     ac_request_q, ac_request_d;
    logic [DATA_W-1:0]   ac_data_q, ac_data_d;
    logic                ac_data_load_q, ac_data_load_d;
    logic                busy_q, busy_d;

    logic [NREQ-1:0]     gnt_c;
    logic [IDX_W-1:0]    gnt_idx_c;
    logic                gnt_vld_c;
    logic [OP_W-1:0]     sel_op_c;
    logic [DATA_W-1:0]   sel_data_c;
    logic                accept_c;
    logic                lock_act_c;

`ifdef ACCESS_LOCKOUT_EN
    localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);
    localparam int unsigned LOCK_W = $clog2(LOCKOUT_CYCLES + 1);

    logic [FAIL_W-1:0]   fail_q, fail_d;
    logic [LOCK_W-1:0]   lock_tmr_q, lock_tmr_d;
    logic                locked_q, locked_d;
`else
    logic                unused_cfg;
    assign unused_cfg = ^{32'(MAX_FAILS), 32'(LOCKOUT_CYCLES)};
`endif

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .gnt_c (gnt_c),
        .idx_c (gnt_idx_c),
        .vld_c (gnt_vld_c)
    );

    // Op/data of the granted requester
    always_comb begin
        sel_op_c   = '0;
        sel_data_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_c[i]) begin
                sel_op_c   = req_op[i*OP_W +: OP_W];
                sel_data_c = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        idx_d          = idx_q;
        tmo_d          = tmo_q;
        rsp_valid_d    = '0;
        rsp_status_d   = '0;
        ac_request_d   = ac_request_q;
        ac_data_d      = ac_data_q;
        ac_data_load_d = 1'b0;
        accept_c       = 1'b0;

`ifdef ACCESS_LOCKOUT_EN
        fail_d     = fail_q;
        lock_tmr_d = lock_tmr_q;
        locked_d   = locked_q;
        // Lockout timer runs in every state; expiry forgives earlier failures
        if (locked_q) begin
            if (lock_tmr_q == LOCK_W'(LOCKOUT_CYCLES - 1)) begin
                locked_d   = 1'b0;
                fail_d     = '0;
                lock_tmr_d = '0;
            end else begin
                lock_tmr_d = lock_tmr_q + 1'b1;
            end
        end
        lock_act_c = locked_d;
`else
        lock_act_c = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (gnt_vld_c) begin
                    accept_c = 1'b1;
                    ptr_d    = (gnt_idx_c == IDX_W'(NREQ - 1)) ? '0 : gnt_idx_c + 1'b1;
                    idx_d    = gnt_idx_c;
                    if (sel_op_c == OP_ILLEGAL) begin
                        state_d      = S_RESP;
                        rsp_valid_d  = gnt_c;
                        rsp_status_d = ST_ENG_ERR;
                    end else begin
                        state_d        = S_ISSUE;
                        ac_request_d   = sel_op_c;
                        ac_data_d      = sel_data_c;
                        ac_data_load_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                tmo_d   = '0;
            end
            S_WAIT: begin
                // A result arriving in the final timeout cycle takes priority
                if (ac_status != ST_NONE || tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d      = S_RESP;
                    rsp_valid_d  = NREQ'(1) << idx_q;
                    rsp_status_d = (ac_status != ST_NONE) ? ac_status : ST_TIMEOUT;
                    ac_request_d = '0;
`ifdef ACCESS_LOCKOUT_EN
                    if (ac_status == ST_GRANTED) begin
                        fail_d = '0;
                    end else if (ac_status == ST_DENIED && ac_request_q == OP_VERIFY) begin
                        fail_d = fail_q + 1'b1;
                        if (fail_q == FAIL_W'(MAX_FAILS - 1)) begin
                            locked_d   = 1'b1;
                            lock_tmr_d = '0;
                        end
                    end
`endif
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_RESP: begin
                state_d = lock_act_c ? S_LOCKOUT : S_IDLE;
            end
            S_LOCKOUT: begin
                if (!lock_act_c) begin
                    state_d = S_IDLE;
                end else if (gnt_vld_c) begin
                    accept_c     = 1'b1;
                    ptr_d        = (gnt_idx_c == IDX_W'(NREQ - 1)) ? '0 : gnt_idx_c + 1'b1;
                    idx_d        = gnt_idx_c;
                    state_d      = S_RESP;
                    rsp_valid_d  = gnt_c;
                    rsp_status_d = ST_LOCKED;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE) && (state_d != S_LOCKOUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            ptr_q          <= '0;
            idx_q          <= '0;
            tmo_q          <= '0;
            rsp_valid_q    <= '0;
            rsp_status_q   <= '0;
            ac_request_q   <= '0;
            ac_data_q      <= '0;
            ac_data_load_q <= 1'b0;
            busy_q         <= 1'b0;
`ifdef ACCESS_LOCKOUT_EN
            fail_q         <= '0;
            lock_tmr_q     <= '0;
            locked_q       <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            idx_q          <= idx_d;
            tmo_q          <= tmo_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_status_q   <= rsp_status_d;
            ac_request_q   <= ac_request_d;
            ac_data_q      <= ac_data_d;
            ac_data_load_q <= ac_data_load_d;
            busy_q         <= busy_d;
`ifdef ACCESS_LOCKOUT_EN
            fail_q         <= fail_d;
            lock_tmr_q     <= lock_tmr_d;
            locked_q       <= locked_d;
`endif
        end
    end

    // Accept pulse is combinational so the requester sees it in the grant cycle
    assign req_ready    = (accept_c && !rst) ? gnt_c : '0;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_status   = rsp_status_q;
    assign ac_request   = ac_request_q;
    assign ac_data      = ac_data_q;
    assign ac_data_load = ac_data_load_q;
    assign busy         = busy_q;
`ifdef ACCESS_LOCKOUT_EN
    assign locked       = locked_q;
`else
    assign locked       = 1'b0;
`endif

endmodule

// File: tb/tb_access_request_sequencer.sv
// Directed bench for access_request_sequencer; the bench itself plays the engine and requesters.
module tb_access_request_sequencer;

    localparam int unsigned NREQ  = 3;
    localparam int unsigned TMO   = 16;
    localparam int unsigned MAXF  = 3;
    localparam int unsigned LOCKC = 40;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req_valid;
    logic [2*NREQ-1:0]  req_op;
    logic [16*NREQ-1:0] req_data;
    logic [NREQ-1:0] req_ready;
    logic [NREQ-1:0] rsp_valid;
    logic [2:0]      rsp_status;
    logic [1:0]      ac_request;
    logic [15:0]     ac_data;
    logic            ac_data_load;
    logic [2:0]      ac_status;
    logic            busy;
    logic            locked;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    access_request_sequencer #(
        .NREQ           (NREQ),
        .TIMEOUT_CYCLES (TMO),
        .MAX_FAILS      (MAXF),
        .LOCKOUT_CYCLES (LOCKC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_op       (req_op),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_status   (rsp_status),
        .ac_request   (ac_request),
        .ac_data      (ac_data),
        .ac_data_load (ac_data_load),
        .ac_status    (ac_status),
        .busy         (busy),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [1:0] op, input logic [15:0] data);
        req_op[r*2 +: 2]    = op;
        req_data[r*16 +: 16] = data;
    endtask

    // Runs from the accept cycle to the response cycle, acting as the engine
    task automatic serve(input int delay, input logic [2:0] estat, input logic drop,
                         input logic [15:0] exp_data, output int lat,
                         output logic [NREQ-1:0] rv, output logic [2:0] rs, output int loads);
        int k;
        k     = 0;
        lat   = -1;
        loads = 0;
        rv    = '0;
        rs    = '0;
        while (lat < 0 && k < int'(TMO) + 8) begin
            step();
            k++;
            if (drop && k == 1) req_valid = '0;
            ac_status = (delay > 0 && k == 1 + delay) ? estat : 3'b000;
            if (ac_data_load) begin
                loads++;
                check("load_data", 32'(ac_data), 32'(exp_data));
            end
            if (rsp_valid != '0) begin
                lat = k;
                rv  = rsp_valid;
                rs  = rsp_status;
            end
        end
        ac_status = 3'b000;
        if (lat < 0) check("rsp_wait_expired", 32'(k), 32'(0));
    endtask

    task automatic txn(input string tag, input int r, input logic [1:0] op, input logic [15:0] data,
                       input int delay, input logic [2:0] estat, input int exp_lat,
                       input logic [2:0] exp_st, input int exp_loads);
        int lat, loads;
        logic [NREQ-1:0] rv, onehot;
        logic [2:0] rs;
        onehot    = NREQ'(1) << r;
        set_req(r, op, data);
        req_valid = onehot;
        #1;
        check($sformatf("%s_ready", tag), 32'(req_ready), 32'(onehot));
        serve(delay, estat, 1'b1, data, lat, rv, rs, loads);
        check($sformatf("%s_lat", tag), 32'(lat), 32'(exp_lat));
        check($sformatf("%s_rspv", tag), 32'(rv), 32'(onehot));
        check($sformatf("%s_status", tag), 32'(rs), 32'(exp_st));
        check($sformatf("%s_loads", tag), 32'(loads), 32'(exp_loads));
        step();
        check($sformatf("%s_idle", tag), 32'(busy), 32'(0));
    endtask

    initial begin
        int rr_exp[4];
        int lat, loads, seen, r0;
        logic [NREQ-1:0] rv;
        logic [2:0] rs;

        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_data  = '0;
        ac_status = 3'b000;
        step();
        step();
        check("rst_rspv", 32'(rsp_valid), 32'(0));
        check("rst_rsps", 32'(rsp_status), 32'(0));
        check("rst_req", 32'(ac_request), 32'(0));
        check("rst_load", 32'(ac_data_load), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_locked", 32'(locked), 32'(0));
        rst = 1'b0;
        step();

        txn("verify", 0, 2'b01, 16'h1234, 5, 3'b001, 7, 3'b001, 1);
        txn("illegal", 1, 2'b00, 16'hBEEF, 0, 3'b000, 1, 3'b100, 0);
        txn("timeout", 2, 2'b01, 16'h5555, 0, 3'b000, int'(TMO) + 2, 3'b111, 1);
        txn("late_win", 0, 2'b10, 16'hCAFE, int'(TMO), 3'b011, int'(TMO) + 2, 3'b011, 1);

        // Reset while waiting on the engine: everything clears, no response ever appears
        set_req(1, 2'b01, 16'h4321);
        req_valid = 3'b010;
        #1;
        check("rstw_ready", 32'(req_ready), 32'(3'b010));
        step();
        req_valid = '0;
        step();
        step();
        rst = 1'b1;
        step();
        check("rstw_rspv", 32'(rsp_valid), 32'(0));
        check("rstw_req", 32'(ac_request), 32'(0));
        check("rstw_data", 32'(ac_data), 32'(0));
        check("rstw_load", 32'(ac_data_load), 32'(0));
        check("rstw_busy", 32'(busy), 32'(0));
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (rsp_valid != '0) seen++;
        end
        check("rstw_no_rsp", 32'(seen), 32'(0));

        // All requesters held valid: grants rotate from index 0 after reset
        rr_exp = '{0, 1, 2, 0};
        for (int i = 0; i < int'(NREQ); i++) set_req(i, 2'b01, 16'hA000 + 16'(i));
        req_valid = 3'b111;
        for (int g = 0; g < 4; g++) begin
            #1;
            check($sformatf("rr%0d_ready", g), 32'(req_ready), 32'(NREQ'(1) << rr_exp[g]));
            serve(1, 3'b001, 1'b0, 16'hA000 + 16'(rr_exp[g]), lat, rv, rs, loads);
            check($sformatf("rr%0d_rspv", g), 32'(rv), 32'(NREQ'(1) << rr_exp[g]));
            check($sformatf("rr%0d_lat", g), 32'(lat), 32'(3));
            if (g == 3) req_valid = '0;
            step();
        end

        txn("deny1", 0, 2'b01, 16'h0001, 2, 3'b010, 4, 3'b010, 1);
        txn("deny2", 0, 2'b01, 16'h0002, 2, 3'b010, 4, 3'b010, 1);
        check("deny2_locked", 32'(locked), 32'(0));
        txn("deny3", 0, 2'b01, 16'h0003, 2, 3'b010, 4, 3'b010, 1);
`ifdef ACCESS_LOCKOUT_EN
        check("deny3_locked", 32'(locked), 32'(1));
        r0 = cyc - 1;
        txn("locked", 0, 2'b01, 16'h0004, 0, 3'b000, 1, 3'b110, 0);
        while (locked && cyc - r0 < int'(LOCKC) + 20) step();
        check("lock_len", 32'(cyc - r0), 32'(LOCKC));
        check("unlocked", 32'(locked), 32'(0));
        txn("unlock", 0, 2'b01, 16'h7777, 3, 3'b001, 5, 3'b001, 1);
`else
        r0 = cyc;
        check("deny3_locked", 32'(locked), 32'(0));
        txn("nolock", 0, 2'b01, 16'h7777, 3, 3'b001, 5, 3'b001, 1);
        check("nolock_cyc", 32'(cyc - r0 > 0), 32'(1));
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
